// File: rtl/led_bank_scheduler.sv
// led_bank_scheduler: round-robin owner of the 3-bit LED bank for three
// requesters, with a req/grant/done handshake and a prescaled tick counter
// (clk_div) that paces dwell and blinking.
// Optional build macro LED_BLINK_EN: blink the granted pattern with clk_div[2].
module led_bank_scheduler #(
   parameter int unsigned DIV_WIDTH  = 4,
   parameter int unsigned HOLD_TICKS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [8:0] pattern,
   output logic [2:0] grant,
   output logic [2:0] done,
   output logic [2:0] led,
   output logic [2:0] clk_div
);

   localparam int unsigned DWELL_W    = DIV_WIDTH + 8;
   localparam int unsigned DWELL_LOAD = HOLD_TICKS * (32'd1 << DIV_WIDTH) - 32'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DIV_WIDTH-1:0] presc;
   logic                 tick;
   logic [2:0]           clk_div_nxt;
   logic [1:0]           last;
   logic [1:0]           last_nxt;
   logic [1:0]           win;
   logic [DWELL_W-1:0]   dwell;
   logic [DWELL_W-1:0]   dwell_nxt;
   logic [2:0]           grant_nxt;
   logic [2:0]           done_nxt;
   logic [2:0]           led_nxt;

   // Round-robin pick: search upward starting after the previous winner.
   function automatic logic [1:0] rr_pick(input logic [1:0] prev, input logic [2:0] r);
      logic [1:0] w;
      w = 2'd0;
      case (prev)
         2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
         2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
         default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
      endcase
      return w;
   endfunction

   function automatic logic [2:0] one_hot(input logic [1:0] idx);
      logic [2:0] h;
      h = 3'b000;
      case (idx)
         2'd0:    h = 3'b001;
         2'd1:    h = 3'b010;
         2'd2:    h = 3'b100;
         default: h = 3'b000;
      endcase
      return h;
   endfunction

   function automatic logic [2:0] sel_pattern(input logic [8:0] p, input logic [1:0] idx);
      logic [2:0] s;
      s = 3'b000;
      case (idx)
         2'd0:    s = p[2:0];
         2'd1:    s = p[5:3];
         2'd2:    s = p[8:6];
         default: s = 3'b000;
      endcase
      return s;
   endfunction

   // LED value presented for a granted pattern; uses next clk_div so the
   // registered led lines up with the registered clk_div.
   function automatic logic [2:0] show(input logic [2:0] p, input logic phase);
`ifdef LED_BLINK_EN
      return p & {3{phase}};
`else
      logic unused_phase;
      unused_phase = phase;
      return p;
`endif
   endfunction

   assign tick        = &presc;
   assign clk_div_nxt = clk_div + {2'b00, tick};
   assign win         = rr_pick(last, req);

   // Free-running prescaler and tick counter, independent of the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc   <= '0;
         clk_div <= 3'd0;
      end else begin
         presc   <= presc + DIV_WIDTH'(1);
         clk_div <= clk_div_nxt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decision; unreachable encodings fall back to IDLE.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = (|req) ? GRANT : IDLE;
         GRANT:   state_nxt = ((dwell == '0) || !(|(req & grant))) ? RELEASE : GRANT;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs, winner and dwell counter.
   always_comb begin
      grant_nxt = 3'b000;
      done_nxt  = 3'b000;
      led_nxt   = 3'b000;
      last_nxt  = last;
      dwell_nxt = dwell;
      case (state)
         IDLE: begin
            if (|req) begin
               last_nxt  = win;
               grant_nxt = one_hot(win);
               led_nxt   = show(sel_pattern(pattern, win), clk_div_nxt[2]);
               dwell_nxt = DWELL_W'(DWELL_LOAD);
            end
         end
         GRANT: begin
            if (state_nxt == GRANT) begin
               grant_nxt = grant;
               led_nxt   = show(sel_pattern(pattern, last), clk_div_nxt[2]);
               dwell_nxt = dwell - DWELL_W'(1);
            end else begin
               done_nxt  = one_hot(last);
            end
         end
         default: begin
            grant_nxt = 3'b000;
         end
      endcase
   end

   // Output, winner and dwell registers; reset clears outputs without a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant <= 3'b000;
         done  <= 3'b000;
         led   <= 3'b000;
         last  <= 2'd2;
         dwell <= '0;
      end else begin
         grant <= grant_nxt;
         done  <= done_nxt;
         led   <= led_nxt;
         last  <= last_nxt;
         dwell <= dwell_nxt;
      end
   end

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Directed bench for led_bank_scheduler with DIV_WIDTH=2, HOLD_TICKS=3
// (12-cycle dwell). Works for both the steady and LED_BLINK_EN builds.
module tb_led_bank_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] req;
   logic [8:0] pattern;
   logic [2:0] grant;
   logic [2:0] done;
   logic [2:0] led;
   logic [2:0] clk_div;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [2:0] pv [3];
   logic [2:0] hot;

   led_bank_scheduler #(.DIV_WIDTH(2), .HOLD_TICKS(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .pattern (pattern),
      .grant   (grant),
      .done    (done),
      .led     (led),
      .clk_div (clk_div)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset release, for the blink phase.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [2:0] exp_led(input logic [2:0] p);
      logic [2:0] d;
      d = 3'((cyc / 4) % 8);
`ifdef LED_BLINK_EN
      return p & {3{d[2]}};
`else
      return p | (d & 3'b000);
`endif
   endfunction

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      req     = 3'b000;
      pattern = 9'd0;
      pv[0] = 3'b011;
      pv[1] = 3'b010;
      pv[2] = 3'b110;

      // Reset state
      #2;
      chk("rst_grant", grant, 3'b000);
      chk("rst_done", done, 3'b000);
      chk("rst_led", led, 3'b000);
      chk("rst_div", clk_div, 3'd0);

      @(negedge clk);
      reset = 1'b1;
      repeat (4) step();
      chk("div_one", clk_div, 3'd1);
      chk("idle_grant", grant, 3'b000);
      chk("idle_led", led, 3'b000);
      chk("idle_done", done, 3'b000);
      repeat (24) step();
      chk("div_seven", clk_div, 3'd7);
      repeat (4) step();
      chk("div_wrap", clk_div, 3'd0);

      // Single requester 1 with a live pattern update mid-grant
      pattern = 9'b000_101_000;
      req     = 3'b010;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("single_grant", grant, 3'b010);
         chk("single_led", led, exp_led((i >= 7) ? 3'b010 : 3'b101));
         chk("single_done0", done, 3'b000);
         if (i == 6) pattern[5:3] = 3'b010;
      end
      step();
      chk("single_drop", grant, 3'b000);
      chk("single_done", done, 3'b010);
      chk("single_ledoff", led, 3'b000);
      req = 3'b000;
      step();
      chk("single_done_end", done, 3'b000);
      chk("single_gap", grant, 3'b000);
      step();
      chk("single_idle", grant, 3'b000);

      // Async reset while requester 2 holds the bank
      pattern = 9'b110_010_011;
      req     = 3'b100;
      step();
      chk("pre_rst_grant", grant, 3'b100);
      chk("pre_rst_led", led, exp_led(3'b110));
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      chk("arst_grant", grant, 3'b000);
      chk("arst_led", led, 3'b000);
      chk("arst_done", done, 3'b000);
      chk("arst_div", clk_div, 3'd0);
      @(negedge clk);
      chk("arst_hold_done", done, 3'b000);
      req   = 3'b111;
      reset = 1'b1;

      // All requesting: strict 0,1,2 rotation starting at requester 0
      for (int k = 0; k < 3; k++) begin
         hot = 3'(32'd1 << k);
         for (int i = 0; i < 12; i++) begin
            step();
            chk("rr_grant", grant, hot);
            chk("rr_led", led, exp_led(pv[k]));
         end
         step();
         chk("rr_drop", grant, 3'b000);
         chk("rr_done", done, hot);
         step();
         chk("rr_gap", grant, 3'b000);
         chk("rr_done_end", done, 3'b000);
      end

      // Wrap back to requester 0, then early release after 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk("wrap_grant", grant, 3'b001);
      end
      req = 3'b110;
      step();
      chk("early_done", done, 3'b001);
      chk("early_drop", grant, 3'b000);
      step();
      chk("early_done_end", done, 3'b000);
      chk("early_gap", grant, 3'b000);
      step();
      chk("early_next", grant, 3'b010);
      req = 3'b000;
      step();
      chk("early2_done", done, 3'b010);
      chk("early2_drop", grant, 3'b000);
      step();
      chk("early2_done_end", done, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
